// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage: FSM states,
// datapath widths and the bit positions of the five instruction fields.
package fetch_pkg;

  localparam int PC_W    = 16;
  localparam int FIELD_W = 5;
  localparam int INSTR_W = 5 * FIELD_W;

  // LSB of each field inside the instruction register; part1 is the opcode
  localparam int P1_LSB = 20;
  localparam int P2_LSB = 15;
  localparam int P3_LSB = 10;
  localparam int P4_LSB = 5;
  localparam int P5_LSB = 0;

  typedef enum logic {
    REQ  = 1'b0,
    FULL = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/next_pc_select.sv
// Redirect arbitration: folds jr/jump/branch into a single redirect flag and
// the winning target address (jr beats jump beats branch).
module next_pc_select #(
  parameter int PC_W = fetch_pkg::PC_W
) (
  input  logic            jr,
  input  logic [PC_W-1:0] jr_address,
  input  logic            jump,
  input  logic [PC_W-1:0] j_address,
  input  logic            branch_taken,
  input  logic [PC_W-1:0] branch_address,
  output logic            redir,
  output logic [PC_W-1:0] target
);

  always_comb begin
    redir  = jr | jump | branch_taken;
    target = branch_address;
    if (jr) begin
      target = jr_address;
    end else if (jump) begin
      target = j_address;
    end
  end

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: holds the PC, requests instruction memory with a req/ready
// handshake and presents one captured instruction at a time to decode.
module instruction_fetch #(
  parameter int                     PC_W     = fetch_pkg::PC_W,
  parameter int                     INSTR_W  = fetch_pkg::INSTR_W,
  parameter int                     FIELD_W  = fetch_pkg::FIELD_W,
  parameter logic [PC_W-1:0]        RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst,
  output logic               mem_req,
  output logic [PC_W-1:0]    mem_addr,
  input  logic               mem_ready,
  input  logic [INSTR_W-1:0] mem_rdata,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [FIELD_W-1:0] part1_out,
  output logic [FIELD_W-1:0] part2_out,
  output logic [FIELD_W-1:0] part3_out,
  output logic [FIELD_W-1:0] part4_out,
  output logic [FIELD_W-1:0] part5_out,
  output logic [PC_W-1:0]    instr_pc,
  input  logic               jr,
  input  logic [PC_W-1:0]    jr_address,
  input  logic               jump,
  input  logic [PC_W-1:0]    j_address,
  input  logic               branch_taken,
  input  logic [PC_W-1:0]    branch_address
);

  import fetch_pkg::*;

  fetch_state_e       state_q, state_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic               pend_q, pend_d;
  logic [PC_W-1:0]    pend_target_q, pend_target_d;
  logic [INSTR_W-1:0] ir_p1, ir_d;
  logic [PC_W-1:0]    instr_pc_p1, instr_pc_d;
  logic               vld_p1, vld_d;
  logic               redir;
  logic [PC_W-1:0]    redir_target;

  next_pc_select #(
    .PC_W(PC_W)
  ) u_next_pc_select (
    .jr            (jr),
    .jr_address    (jr_address),
    .jump          (jump),
    .j_address     (j_address),
    .branch_taken  (branch_taken),
    .branch_address(branch_address),
    .redir         (redir),
    .target        (redir_target)
  );

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    pend_d        = pend_q;
    pend_target_d = pend_target_q;
    ir_d          = ir_p1;
    instr_pc_d    = instr_pc_p1;
    vld_d         = vld_p1;
    unique case (state_q)
      REQ: begin
        if (mem_ready) begin
          // A redirect seen while the request was outstanding makes the
          // returned word stale; the live redirect wins over a pending one.
          if (redir) begin
            pc_d   = redir_target;
            pend_d = 1'b0;
          end else if (pend_q) begin
            pc_d   = pend_target_q;
            pend_d = 1'b0;
          end else begin
            ir_d       = mem_rdata;
            instr_pc_d = pc_q;
            vld_d      = 1'b1;
            pc_d       = pc_q + PC_W'(1);
            state_d    = FULL;
          end
        end else if (redir) begin
          pend_d        = 1'b1;
          pend_target_d = redir_target;
        end
      end
      FULL: begin
        if (redir) begin
          vld_d   = 1'b0;
          pc_d    = redir_target;
          state_d = REQ;
        end else if (out_ready) begin
          vld_d   = 1'b0;
          state_d = REQ;
        end
      end
      default: state_d = REQ;
    endcase
  end

  // Stage boundary: PC/control registers and the instruction register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= REQ;
      pc_q          <= RESET_PC;
      pend_q        <= 1'b0;
      pend_target_q <= '0;
      ir_p1         <= '0;
      instr_pc_p1   <= '0;
      vld_p1        <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      pend_q        <= pend_d;
      pend_target_q <= pend_target_d;
      ir_p1         <= ir_d;
      instr_pc_p1   <= instr_pc_d;
      vld_p1        <= vld_d;
    end
  end

  assign mem_req   = (state_q == REQ) && !rst;
  assign mem_addr  = pc_q;
  assign out_valid = vld_p1;
  assign instr_pc  = instr_pc_p1;
  assign part1_out = ir_p1[P1_LSB +: FIELD_W];
  assign part2_out = ir_p1[P2_LSB +: FIELD_W];
  assign part3_out = ir_p1[P3_LSB +: FIELD_W];
  assign part4_out = ir_p1[P4_LSB +: FIELD_W];
  assign part5_out = ir_p1[P5_LSB +: FIELD_W];

endmodule

// File: doc/instruction_fetch.md
Name: instruction_fetch

Overview:
- Fetch stage directly upstream of the control unit.
- Holds the 16-bit word-addressed PC and issues requests to instruction memory through a req/ready handshake.
- Captures each 25-bit instruction in a one-entry instruction register (IR) and presents it to decode as five 5-bit fields (part1 = opcode).
- Accepts jump, taken-branch and jr redirects, and flushes the IR on a redirect.

Parameters:
- PC_W, 16, PC and target address width.
- INSTR_W, 25, instruction width (5 fields x FIELD_W).
- FIELD_W, 5, width of each instruction field.
- RESET_PC, 16'h0000, PC value loaded on reset.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- mem_req  out  1  instruction memory request.
- mem_addr  out  PC_W  request address; equals pc while mem_req=1.
- mem_ready  in  1  memory has returned data for the current request.
- mem_rdata  in  INSTR_W  instruction data; valid when mem_ready=1.
- out_valid  out  1  IR holds a valid instruction for decode.
- out_ready  in  1  decode accepts the IR this cycle.
- part1_out  out  FIELD_W  IR[24:20], opcode.
- part2_out  out  FIELD_W  IR[19:15].
- part3_out  out  FIELD_W  IR[14:10].
- part4_out  out  FIELD_W  IR[9:5].
- part5_out  out  FIELD_W  IR[4:0].
- instr_pc  out  PC_W  address of the instruction in the IR.
- jr  in  1  redirect to jr_address.
- jr_address  in  PC_W  register-sourced target.
- jump  in  1  redirect to j_address.
- j_address  in  PC_W  absolute jump target.
- branch_taken  in  1  redirect to branch_address.
- branch_address  in  PC_W  absolute branch target (zero-extended by decode).

Behaviour:
- Reset (rst=1 at an edge):
  - pc=RESET_PC, state=REQ, IR=0, out_valid=0, instr_pc=0, pend=0.
  - mem_req=0 during the reset cycle; mem_req=1 from the first cycle after rst falls.
  - Reset mid-request abandons the request; any late mem_ready is ignored until state=REQ is re-entered.
- Redirect:
  - redir = jr | jump | branch_taken.
  - Priority for target selection: jr > jump > branch_taken.
- State REQ: mem_req=1, mem_addr=pc. Address and request are held stable until mem_ready.
  - mem_ready=1, no redirect and pend=0: IR<=mem_rdata, instr_pc<=pc, out_valid<=1, pc<=pc+1 (wraps 16'hFFFF->0), go to FULL.
  - mem_ready=1 with redir or pend: discard data; pc<=selected target (current redir beats the pending target); pend<=0; stay in REQ.
  - mem_ready=0 with redir: pend<=1, pend_target<=target. A later redir overwrites pend_target. mem_addr is unchanged.
- State FULL: mem_req=0. The IR is held stable while out_valid=1 and out_ready=0.
  - out_ready=1, no redir: out_valid<=0, go to REQ.
  - redir (with or without out_ready): out_valid<=0 (flush), pc<=target, go to REQ. A coincident out_ready still counts as a completed transfer.
- Latency and throughput:
  - Zero-wait memory: out_valid rises 1 cycle after mem_req rises.
  - Peak throughput is 1 instruction per 2 cycles. Prefetch is not supported.
- Width rules:
  - pc+1 is modulo 2^PC_W; there is no overflow flag.
  - Fields are pure bit slices of the IR.

Decomposition:
- Shared package fetch_pkg:
  - state enum {REQ, FULL};
  - FIELD_W, INSTR_W, PC_W constants;
  - field slice index constants.
- One combinational sub-module, next_pc_select: inputs jr/jump/branch_taken plus their addresses; outputs redir and the prioritised target.

Test Plan:
- Reset, memory returns 25'h0A5_2C31 at addr 0 with zero wait, out_ready=1 -> mem_addr sequence 0,1,2...; out_valid every other cycle; part1..part5 = 25'h0A5_2C31 sliced into 5-bit fields; instr_pc=0.
- mem_ready delayed 3 cycles at addr 5 -> mem_req and mem_addr=5 held for all 3 cycles; IR captured on the 4th cycle.
- IR valid, out_ready=0 for 4 cycles -> mem_req=0 and part*_out stable; raising out_ready gives mem_addr=pc+1 on the next cycle.
- In FULL: jump=1, j_address=16'h0040 -> out_valid=0 next cycle; mem_addr=16'h0040.
- In REQ, waiting: branch_taken with 16'h0010 -> mem_addr unchanged; mem_ready data discarded; next mem_addr=16'h0010.
- jr (16'h0100) and jump (16'h0200) asserted in the same cycle -> target 16'h0100.
- pc=16'hFFFF fetched -> next mem_addr=16'h0000.
- rst asserted mid-wait -> pc=0 and out_valid=0; a stale mem_ready in the reset cycle is ignored.
